// File: rtl/counter_ctrl_74161.sv
// Control stage for a 74161-style 4-bit counter: programmable divide-by-N timebase
// with start/stop, wrap detection and period counting. Optional QC tracker: QC_CHECK_EN.
module counter_ctrl_74161 #(
  parameter int unsigned N_PERIODS = 0,
  parameter int unsigned PERIODS_W = 8
) (
  input  logic                 CLK,
  input  logic                 CLRBAR,
  input  logic                 START,
  input  logic                 STOP,
  input  logic [3:0]           MODN,
  input  logic                 RCO_IN,
  input  logic [3:0]           QC_IN,
  output logic [3:0]           DIC,
  output logic                 LOAD,
  output logic                 ENP,
  output logic                 ENT,
  output logic                 TICK,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [PERIODS_W-1:0] PERIODS,
  output logic                 ERR
);

  typedef enum logic [1:0] {S_IDLE, S_PRELOAD, S_RUN, S_DONE} state_t;

  localparam logic [PERIODS_W-1:0] PER_LIMIT = PERIODS_W'(N_PERIODS);
  localparam bit                   AUTO_STOP = (N_PERIODS != 0);

  state_t               state_q, state_d;
  logic [3:0]           dic_q, dic_d;
  logic                 tick_q, tick_d;
  logic [PERIODS_W-1:0] per_q, per_d;
  logic [PERIODS_W-1:0] per_inc;
  logic [3:0]           preset;
  logic                 accept;

  // 16 - N modulo 16, so MODN=0 yields preset 0 and a 16-cycle period.
  assign preset  = 4'd0 - MODN;
  assign per_inc = (&per_q) ? per_q : per_q + PERIODS_W'(1);
  assign accept  = ((state_q == S_IDLE) || (state_q == S_DONE)) && START && !STOP;

  always_comb begin
    state_d = state_q;
    dic_d   = dic_q;
    tick_d  = 1'b0;
    per_d   = per_q;
    LOAD    = 1'b1;
    ENP     = 1'b0;
    ENT     = 1'b1;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        DONE = (state_q == S_DONE);
        if (STOP) begin
          state_d = S_IDLE;
        end else if (START) begin
          state_d = S_PRELOAD;
          dic_d   = preset;
          per_d   = '0;
        end
      end
      S_PRELOAD: begin
        LOAD    = 1'b0;
        ENP     = 1'b1;
        BUSY    = 1'b1;
        state_d = STOP ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        // Reload on terminal count instead of wrapping through 0.
        LOAD = ~RCO_IN;
        ENP  = 1'b1;
        BUSY = 1'b1;
        if (RCO_IN) begin
          tick_d = 1'b1;
          per_d  = per_inc;
        end
        if (STOP) begin
          state_d = S_IDLE;
        end else if (RCO_IN && AUTO_STOP && (per_inc == PER_LIMIT)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLRBAR) begin
    if (!CLRBAR) begin
      state_q <= S_IDLE;
      dic_q   <= '0;
      tick_q  <= 1'b0;
      per_q   <= '0;
    end else begin
      state_q <= state_d;
      dic_q   <= dic_d;
      tick_q  <= tick_d;
      per_q   <= per_d;
    end
  end

  assign DIC     = dic_q;
  assign TICK    = tick_q;
  assign PERIODS = per_q;

`ifdef QC_CHECK_EN
  logic [3:0] exp_q, exp_d;
  logic       err_q, err_d;

  always_comb begin
    exp_d = exp_q;
    err_d = err_q;
    if (accept) err_d = 1'b0;
    if (state_q == S_PRELOAD) exp_d = dic_q;
    if (state_q == S_RUN) begin
      if (QC_IN != exp_q) err_d = 1'b1;
      exp_d = (exp_q == 4'hF) ? dic_q : exp_q + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge CLRBAR) begin
    if (!CLRBAR) begin
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  logic unused_qc;
  assign unused_qc = ^{QC_IN, accept};
  assign ERR       = 1'b0;
`endif

endmodule

// File: doc/counter_ctrl_74161.md
Name: counter_ctrl_74161

Overview:
- Control stage that sits directly upstream of a 4-bit synchronous 74161-style counter.
- Drives the counter's DIC, LOAD, ENP and ENT inputs and consumes its RCO and QC outputs, turning the counter into a programmable divide-by-N timebase.
- Start/stop control, wrap detection, period counting, and an optional period-limit stop.
- Outputs TICK/PERIODS/DONE feed downstream sequencing (e.g. shift-register clock-enable).

Parameters:
N_PERIODS, 0, number of divider periods to run before auto-stop; 0 = run until STOP
PERIODS_W, 8, width of PERIODS output counter

Ports:
CLK  input  1  clock, rising edge; shared with the driven counter
CLRBAR  input  1  asynchronous active-low reset
START  input  1  start request, sampled on CLK rising edge
STOP  input  1  stop request, sampled on CLK rising edge; priority over START
MODN  input  4  divide ratio N, 1..15; 0 means 16; captured on accepted START
RCO_IN  input  1  counter ripple-carry output (high when QC=15)
QC_IN  input  4  counter parallel output
DIC  output  4  counter preset value, registered
LOAD  output  1  counter LOAD input
ENP  output  1  counter ENP input
ENT  output  1  counter ENT input
TICK  output  1  one-cycle pulse per completed period, registered
BUSY  output  1  high in PRELOAD and RUN
DONE  output  1  high in DONE state
PERIODS  output  PERIODS_W  completed periods since last START; saturates at all-ones
ERR  output  1  sticky QC mismatch flag (optional feature)

Behaviour:
- Counter command encoding driven by this block:
  - HOLD = ENP=0, ENT=1, LOAD=1
  - LOAD = ENP=1, ENT=1, LOAD=0 (counter takes DIC next edge)
  - COUNT = ENP=1, ENT=1, LOAD=1
- Reset (CLRBAR=0, async): state IDLE, DIC=0, LOAD=1, ENP=0, ENT=1, TICK=0, BUSY=0, DONE=0, PERIODS=0, ERR=0.
- Preset: P = 16 - N mod 16 (MODN=0 -> P=0). Counter visits P..15, so period = N cycles (16 for MODN=0).
- States: IDLE, PRELOAD, RUN, DONE.
  - IDLE: command HOLD. On START=1 and STOP=0: capture MODN, set DIC=P, clear PERIODS, TICK and ERR, go PRELOAD.
  - PRELOAD (exactly 1 cycle): command LOAD. Next state RUN; counter holds P after this edge.
  - RUN: command COUNT, except LOAD=~RCO_IN, so that on QC=15 the counter reloads P instead of wrapping.
    - LOAD is the only combinational output path (RCO_IN -> LOAD).
    - Each cycle with RCO_IN=1 in RUN: TICK=1 on the following cycle, PERIODS+1 (saturating).
  - DONE: command HOLD, DONE=1. START goes to PRELOAD, same capture as IDLE.
- Auto-stop: if N_PERIODS != 0 and the increment makes PERIODS equal N_PERIODS, go to DONE at that edge. The reload to P still occurs on that edge.
- STOP=1 in PRELOAD or RUN: go to IDLE at that edge. Outputs during the STOP cycle are still PRELOAD/RUN, so the counter performs that final load/count, then holds. PERIODS and DIC are retained.
- STOP=1 in DONE: go to IDLE. STOP and START together: STOP wins, START ignored.
- START in PRELOAD/RUN is ignored. MODN changes are ignored outside START capture.
- RCO_IN is ignored outside RUN. TICK is never asserted outside the cycle after a RUN wrap.
- Reset mid-operation: immediate return to reset values; counter is left in HOLD command.

Optional Feature:
- Macro QC_CHECK_EN.
- Defined: an internal expected-value register tracks the counter.
  - Set to P on the PRELOAD edge.
  - In RUN: +1 per cycle, or back to P when expected=15.
  - Any RUN cycle with QC_IN != expected sets ERR. ERR stays set until START is accepted or reset.
- Undefined: no tracker logic; ERR tied to 0.

Test Plan:
- Reset: CLRBAR=0 mid-RUN -> all outputs at reset values immediately, without waiting for a clock edge; ENP=0, LOAD=1.
- MODN=5, START pulse -> DIC=11; PRELOAD cycle LOAD=0; QC sequence 11,12,13,14,15,11...; TICK every 5 cycles; PERIODS=1,2,3...
- MODN=0 -> DIC=0, period 16 cycles; LOAD low in RUN only while QC=15.
- N_PERIODS=3, MODN=2 -> DONE=1 and BUSY=0 after 3rd period (6 RUN cycles); counter holds at 14; PERIODS=3.
- STOP asserted with START in RUN, then STOP+START together in IDLE -> stops after one final count; stays IDLE; PERIODS retained.
- QC_CHECK_EN defined, QC_IN forced to 0 for one RUN cycle -> ERR=1 next cycle and stays 1 until next START.
